// File: rtl/led_result_sequencer.sv
// Queues 3-bit result codes in a small FIFO and presents each one to the LED decoder
// for HOLD_CYCLES, separated by a GAP_CYCLES blank.
module led_result_sequencer #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_val,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [2:0]               disp_val,
  output logic                     disp_en,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int MAXC_RAW = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC     = (MAXC_RAW > 2) ? MAXC_RAW : 2;
  localparam int CW       = $clog2(MAXC);
  localparam int PW       = $clog2(DEPTH);
  localparam int FW       = PW + 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [2:0]      disp_val_q, disp_val_d;
  logic [2:0]      mem_q [DEPTH];
  logic            push;
  logic            pop;
  logic            wr_en;

  assign in_ready = (fill_q != FW'(DEPTH));
  assign disp_en  = (state_q == ST_SHOW);
  assign disp_val = disp_val_q;
  assign busy     = (state_q != ST_IDLE) || (fill_q != '0);
  assign fill     = fill_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    disp_val_d = disp_val_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    pop        = 1'b0;
    push       = in_valid && in_ready;

    case (state_q)
      ST_IDLE: begin
        if (fill_q != '0) begin
          pop     = 1'b1;
          state_d = ST_SHOW;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else if (fill_q != '0) begin
          // no gap configured: chain straight into the next queued code
          pop   = 1'b1;
          cnt_d = HOLD_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (fill_q != '0) begin
          pop     = 1'b1;
          state_d = ST_SHOW;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      disp_val_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    wr_en = push && !flush;
    if (flush) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      disp_val_d = disp_val_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      disp_val_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      disp_val_q <= disp_val_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'b000;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= in_val;
    end
  end

endmodule

// File: tb/tb_led_result_sequencer.sv
// Directed bench for led_result_sequencer: one gapped instance (3/1/4) and one
// gap-less instance (3/0/4).
module tb_led_result_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid, in_valid0;
  logic [2:0] in_val, in_val0;
  logic       in_ready, in_ready0;
  logic [2:0] disp_val, disp_val0;
  logic       disp_en, disp_en0;
  logic       busy, busy0;
  logic [2:0] fill, fill0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_result_sequencer #(.HOLD_CYCLES(3), .GAP_CYCLES(1), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_val(in_val),
    .in_ready(in_ready), .flush(flush), .disp_val(disp_val),
    .disp_en(disp_en), .busy(busy), .fill(fill)
  );

  led_result_sequencer #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_val(in_val0),
    .in_ready(in_ready0), .flush(flush), .disp_val(disp_val0),
    .disp_en(disp_en0), .busy(busy0), .fill(fill0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_val = 3'd0; in_valid0 = 1'b0; in_val0 = 3'd0;
    #3;
    checks++; if (disp_val !== 3'd0) begin errors++; $display("FAIL rst_disp_val got %0d exp 0", disp_val); end
    checks++; if (disp_en !== 1'b0) begin errors++; $display("FAIL rst_disp_en got %0b exp 0", disp_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_val = 3'b010;
    tick();
    in_valid = 1'b0;
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL single_fill_e0 got %0d exp 1", fill); end
    checks++; if (disp_en !== 1'b0) begin errors++; $display("FAIL single_en_e0 got %0b exp 0", disp_en); end
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++; if (disp_en !== (e <= 3)) begin errors++; $display("FAIL single_en e%0d got %0b exp %0b", e, disp_en, (e <= 3)); end
      if (e <= 3) begin
        checks++; if (disp_val !== 3'd2) begin errors++; $display("FAIL single_val e%0d got %0d exp 2", e, disp_val); end
      end
      checks++; if (busy !== (e <= 4)) begin errors++; $display("FAIL single_busy e%0d got %0b exp %0b", e, busy, (e <= 4)); end
    end
  endtask

  task automatic test_back_to_back();
    int en_tab[10]   = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
    int val_tab[10]  = '{0, 0, 0, 0, 0, 3, 3, 3, 0, 0};
    int fill_tab[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    in_valid = 1'b1; in_val = 3'd0;
    tick();
    in_val = 3'd3;
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL b2b_fill e0 got %0d exp 1", fill); end
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 1) in_valid = 1'b0;
      checks++; if (disp_en !== en_tab[e][0]) begin errors++; $display("FAIL b2b_en e%0d got %0b exp %0d", e, disp_en, en_tab[e]); end
      if (en_tab[e] != 0) begin
        checks++; if (disp_val !== val_tab[e][2:0]) begin errors++; $display("FAIL b2b_val e%0d got %0d exp %0d", e, disp_val, val_tab[e]); end
      end
      checks++; if (fill !== fill_tab[e][2:0]) begin errors++; $display("FAIL b2b_fill e%0d got %0d exp %0d", e, fill, fill_tab[e]); end
    end
  endtask

  task automatic test_fill_stall();
    logic [2:0] codes[6] = '{3'd5, 3'd1, 3'd7, 3'd2, 3'd6, 3'd3};
    logic [2:0] shown[$];
    int idx = 0;
    logic prev_en, rdy, saw_full;
    bit done = 0;
    prev_en = disp_en;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (idx < 6) begin in_valid = 1'b1; in_val = codes[idx]; end
      else in_valid = 1'b0;
      rdy = in_ready;
      checks++; if (in_ready !== (fill != 3'd4)) begin errors++; $display("FAIL stall_ready cyc%0d got %0b fill %0d", cyc, in_ready, fill); end
      if (fill == 3'd4 && in_ready == 1'b0) saw_full = 1'b1;
      tick();
      if (in_valid && rdy) idx++;
      if (disp_en && !prev_en) shown.push_back(disp_val);
      prev_en = disp_en;
      if (idx == 6 && !busy) done = 1;
    end
    in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout got idx %0d shown %0d exp drained", idx, shown.size()); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL stall_full_seen got %0b exp 1", saw_full); end
    checks++; if (shown.size() != 6) begin errors++; $display("FAIL stall_count got %0d exp 6", shown.size()); end
    for (int i = 0; i < 6 && i < shown.size(); i++) begin
      checks++; if (shown[i] !== codes[i]) begin errors++; $display("FAIL stall_order idx%0d got %0d exp %0d", i, shown[i], codes[i]); end
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    for (int e = 0; e < 4; e++) begin
      in_val = 3'(e + 1);
      tick();
    end
    checks++; if (fill !== 3'd3) begin errors++; $display("FAIL flush_pre_fill got %0d exp 3", fill); end
    checks++; if (disp_en !== 1'b1) begin errors++; $display("FAIL flush_pre_en got %0b exp 1", disp_en); end
    flush = 1'b1; in_val = 3'd5;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (disp_en !== 1'b0) begin errors++; $display("FAIL flush_en got %0b exp 0", disp_en); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL flush_fill got %0d exp 0", fill); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b exp 0", busy); end
    tick(); tick();
    checks++; if (disp_en !== 1'b0) begin errors++; $display("FAIL flush_discard_en got %0b exp 0", disp_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_discard_busy got %0b exp 0", busy); end
  endtask

  task automatic test_reset_gap();
    in_valid = 1'b1; in_val = 3'd6;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (disp_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rgap_pre got en %0b busy %0b exp 0 1", disp_en, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (disp_val !== 3'd0) begin errors++; $display("FAIL rgap_val got %0d exp 0", disp_val); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rgap_busy got %0b exp 0", busy); end
    checks++; if (fill !== 3'd0 || in_ready !== 1'b1 || disp_en !== 1'b0) begin errors++; $display("FAIL rgap_misc got fill %0d rdy %0b en %0b exp 0 1 0", fill, in_ready, disp_en); end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_val = 3'd5;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (disp_en !== 1'b1 || disp_val !== 3'd5) begin errors++; $display("FAIL rgap_after got en %0b val %0d exp 1 5", disp_en, disp_val); end
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rgap_drain_busy got %0b exp 0", busy); end
  endtask

  task automatic test_no_gap();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tick();
    in_valid0 = 1'b1; in_val0 = 3'd4;
    tick();
    in_val0 = 3'd7;
    tick();
    in_valid0 = 1'b0;
    checks++; if (disp_en0 !== 1'b1 || disp_val0 !== 3'd4) begin errors++; $display("FAIL nogap e1 got en %0b val %0d exp 1 4", disp_en0, disp_val0); end
    checks++; if (fill0 !== 3'd1) begin errors++; $display("FAIL nogap_fill e1 got %0d exp 1", fill0); end
    for (int e = 2; e <= 7; e++) begin
      tick();
      checks++; if (disp_en0 !== (e <= 6)) begin errors++; $display("FAIL nogap_en e%0d got %0b exp %0b", e, disp_en0, (e <= 6)); end
      if (e <= 6) begin
        checks++; if (disp_val0 !== ((e <= 3) ? 3'd4 : 3'd7)) begin errors++; $display("FAIL nogap_val e%0d got %0d exp %0d", e, disp_val0, (e <= 3) ? 4 : 7); end
      end
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL nogap_busy got %0b exp 0", busy0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_stall();
    test_flush();
    test_reset_gap();
    test_no_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
